// File: rtl/sar_result_avg_fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sar_result_avg_fifo_pkg                                      |
// | Purpose  : Shared constants for the SAR result averaging path. The      |
// |            conversion width is common with the SAR logic; the averaging |
// |            and buffering defaults live here so every user agrees.       |
// | Contents : SAR_DATA_W, DEF_AVG_LOG2, DEF_FIFO_DEPTH, lvl_width()        |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package sar_result_avg_fifo_pkg;

  localparam int SAR_DATA_W     = 8;
  localparam int DEF_AVG_LOG2   = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_result_avg_fifo_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sar_result_avg_fifo_if                                       |
// | Purpose  : Bundles the conversion input, the flush request and the     |
// |            averaged-result valid/ready stream of sar_result_avg_fifo.   |
// | Signals  : eoc, sar, clr            conversion side / flush            |
// |            out_data, out_valid,     averaged-result stream             |
// |            out_ready                                                    |
// |            fifo_level, ovf          status                             |
// | Modports : master - environment (SAR logic + readout stage)            |
// |            slave  - the averaging block                                |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface sar_result_avg_fifo_if
  import sar_result_avg_fifo_pkg::*;
#(
  parameter int DATA_W     = SAR_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int LVL_W = lvl_width(FIFO_DEPTH);

  logic              eoc;
  logic [DATA_W-1:0] sar;
  logic              clr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  fifo_level;
  logic              ovf;

  modport master (
    output eoc, sar, clr, out_ready,
    input  out_data, out_valid, fifo_level, ovf
  );

  modport slave (
    input  eoc, sar, clr, out_ready,
    output out_data, out_valid, fifo_level, ovf
  );

endinterface
`default_nettype wire

// File: rtl/sar_result_avg_fifo_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sar_sync_fifo                                               |
// | Purpose  : Small synchronous first-word fall-through FIFO. The head     |
// |            entry is visible on pop_data whenever the FIFO is not empty |
// |            (zero when empty). A push into a full FIFO is accepted only |
// |            if a pop happens in the same cycle; a pop when empty is     |
// |            ignored.                                                    |
// | Ports    : clk, rst (sync, active high), clr (sync flush)              |
// |            push, push_data  write side                                 |
// |            pop, pop_data    read side (FWFT)                           |
// |            full, empty, level  status                                  |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module sar_sync_fifo
  import sar_result_avg_fifo_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = lvl_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty    = (r_level == '0);
  assign full     = (r_level == LW'(DEPTH));
  assign level    = r_level;
  assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

  // A simultaneous pop frees the slot, so a full FIFO can still take a push.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // DEPTH is a power of two, so the pointers wrap on their natural overflow.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: unread slots are never presented.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sar_result_avg_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sar_result_avg_fifo                                          |
// | Purpose  : Averages 2**AVG_LOG2 consecutive SAR conversion results and |
// |            buffers the averages in a FWFT FIFO presented as a          |
// |            valid/ready stream. Sticky ovf flags a dropped average.     |
// | Ports    : clk  system clock, rising edge                              |
// |            rst  synchronous active-high reset                          |
// |            bus  sar_result_avg_fifo_if.slave: eoc, sar, clr,            |
// |                 out_data, out_valid, out_ready, fifo_level, ovf        |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module sar_result_avg_fifo
  import sar_result_avg_fifo_pkg::*;
#(
  parameter int DATA_W     = SAR_DATA_W,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  sar_result_avg_fifo_if.slave  bus
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int LVL_W = lvl_width(FIFO_DEPTH);

  logic              w_take;
  logic              w_push;
  logic [DATA_W-1:0] w_push_data;
  logic [DATA_W-1:0] w_pop_data;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [LVL_W-1:0]  w_level;
  logic              r_ovf;

  // A flush in the same cycle as eoc discards that sample.
  assign w_take = bus.eoc & ~bus.clr;

  generate
    if (AVG_LOG2 == 0) begin : g_pass
      assign w_push      = w_take;
      assign w_push_data = bus.sar;
    end else begin : g_avg
      logic [ACC_W-1:0]    r_acc;
      logic [AVG_LOG2-1:0] r_cnt;
      logic [ACC_W-1:0]    w_sum;
      logic                w_last;

      // ACC_W holds 2**AVG_LOG2 full-scale samples, so the sum never wraps.
      assign w_sum       = r_acc + ACC_W'(bus.sar);
      assign w_last      = &r_cnt;
      assign w_push      = w_take & w_last;
      assign w_push_data = w_sum[ACC_W-1:AVG_LOG2];

      always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else if (w_take) begin
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + AVG_LOG2'(1);
          end
        end
      end
    end
  endgenerate

  sar_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.clr),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (bus.out_ready),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  // Mirrors the FIFO's own accept rule to detect a dropped average.
  assign w_pop = bus.out_ready & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.out_data   = w_pop_data;
  assign bus.out_valid  = ~w_empty;
  assign bus.fifo_level = w_level;
  assign bus.ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sar_result_avg_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_sar_result_avg_fifo                                       |
// | Purpose  : Self-checking bench for sar_result_avg_fifo. Two instances  |
// |            (4-sample averaging and pass-through) share one stimulus;   |
// |            a queue-based reference model predicts every output on      |
// |            every cycle, and directed scenarios pin literal values.     |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_sar_result_avg_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       eoc = 1'b0;
  logic [7:0] sar = '0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;
  bit         chk_en = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sar_result_avg_fifo_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) if_a ();
  sar_result_avg_fifo_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) if_b ();

  assign if_a.eoc = eoc;  assign if_a.sar = sar;
  assign if_a.clr = clr;  assign if_a.out_ready = out_ready;
  assign if_b.eoc = eoc;  assign if_b.sar = sar;
  assign if_b.clr = clr;  assign if_b.out_ready = out_ready;

  sar_result_avg_fifo #(.DATA_W(8), .AVG_LOG2(2), .FIFO_DEPTH(DEPTH)) u_dut_avg (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  sar_result_avg_fifo #(.DATA_W(8), .AVG_LOG2(0), .FIFO_DEPTH(DEPTH)) u_dut_pass (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: queue of completed averages ----------------
  int mq [2][$];
  int macc [2];
  int mcnt [2];
  bit movf [2];

  always @(posedge clk) begin
    int  n;
    int  v;
    bit  pop;
    bit  push;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 1;
      if (rst || clr) begin
        mq[k].delete();
        macc[k] = 0;
        mcnt[k] = 0;
        movf[k] = 1'b0;
      end else begin
        pop  = (mq[k].size() > 0) && out_ready;
        push = 1'b0;
        v    = 0;
        if (eoc) begin
          macc[k] += int'(sar);
          mcnt[k]++;
          if (mcnt[k] == n) begin
            push    = 1'b1;
            v       = macc[k] / n;
            macc[k] = 0;
            mcnt[k] = 0;
          end
        end
        if (pop) void'(mq[k].pop_front());
        if (push) begin
          if (mq[k].size() < DEPTH) mq[k].push_back(v);
          else movf[k] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int ed;
        ed = (mq[k].size() > 0) ? mq[k][0] : 0;
        if (k == 0) begin
          check("avg.out_valid",  32'(if_a.out_valid),  32'(mq[0].size() > 0));
          check("avg.out_data",   32'(if_a.out_data),   32'(ed));
          check("avg.fifo_level", 32'(if_a.fifo_level), 32'(mq[0].size()));
          check("avg.ovf",        32'(if_a.ovf),        32'(movf[0]));
        end else begin
          check("pass.out_valid",  32'(if_b.out_valid),  32'(mq[1].size() > 0));
          check("pass.out_data",   32'(if_b.out_data),   32'(ed));
          check("pass.fifo_level", 32'(if_b.fifo_level), 32'(mq[1].size()));
          check("pass.ovf",        32'(if_b.ovf),        32'(movf[1]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One eoc cycle; afterwards the bench sits one step past the sampling edge.
  task automatic do_eoc(input logic [7:0] v);
    eoc = 1'b1;
    sar = v;
    tick();
    eoc = 1'b0;
  endtask

  task automatic sample(input logic [7:0] v);
    do_eoc(v);
    idle(3);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    idle(2);
    check("rst.out_valid",  32'(if_a.out_valid),  32'd0);
    check("rst.out_data",   32'(if_a.out_data),   32'd0);
    check("rst.fifo_level", 32'(if_a.fifo_level), 32'd0);
    check("rst.ovf",        32'(if_a.ovf),        32'd0);
    rst = 1'b0;
    tick();

    // 1: 10,20,30,41 -> 25, nothing before the fourth sample
    out_ready = 1'b1;
    sample(8'd10);
    sample(8'd20);
    sample(8'd30);
    check("t1.no_early_output", 32'(if_a.out_valid), 32'd0);
    do_eoc(8'd41);
    check("t1.out_valid", 32'(if_a.out_valid), 32'd1);
    check("t1.out_data",  32'(if_a.out_data),  32'd25);
    idle(3);

    // 2: full-scale samples do not wrap the accumulator
    sample(8'hFF); sample(8'hFF); sample(8'hFF);
    do_eoc(8'hFF);
    check("t2.out_data", 32'(if_a.out_data), 32'hFF);
    idle(3);

    // 3: fill and overflow, then drain in order
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      for (int j = 0; j < 4; j++) sample(8'(k));
    check("t3.level", 32'(if_a.fifo_level), 32'd4);
    check("t3.ovf",   32'(if_a.ovf),        32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("t3.drain_data", 32'(if_a.out_data), 32'(i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("t3.empty_after_drain", 32'(if_a.out_valid), 32'd0);

    // 4: full FIFO, push and pop in the same cycle
    pulse_clr();
    check("t4.ovf_cleared", 32'(if_a.ovf),        32'd0);
    check("t4.level_clr",   32'(if_a.fifo_level), 32'd0);
    for (int k = 5; k <= 8; k++)
      for (int j = 0; j < 4; j++) sample(8'(k));
    check("t4.level_full", 32'(if_a.fifo_level), 32'd4);
    sample(8'd9); sample(8'd9); sample(8'd9);
    out_ready = 1'b1;
    do_eoc(8'd9);
    out_ready = 1'b0;
    check("t4.level_kept", 32'(if_a.fifo_level), 32'd4);
    check("t4.ovf_clear",  32'(if_a.ovf),        32'd0);
    check("t4.head",       32'(if_a.out_data),   32'd6);
    idle(3);

    // 5: clr mid-average and clr coincident with eoc
    pulse_clr();
    out_ready = 1'b1;
    sample(8'd100);
    sample(8'd100);
    clr = 1'b1; eoc = 1'b1; sar = 8'd200;
    tick();
    clr = 1'b0; eoc = 1'b0;
    sample(8'd8); sample(8'd8); sample(8'd8);
    check("t5.no_early_output", 32'(if_a.out_valid), 32'd0);
    do_eoc(8'd8);
    check("t5.out_valid", 32'(if_a.out_valid), 32'd1);
    check("t5.out_data",  32'(if_a.out_data),  32'd8);
    check("t5.ovf",       32'(if_a.ovf),       32'd0);
    idle(3);

    // 6: pass-through, then reset mid-stream
    out_ready = 1'b0;
    pulse_clr();
    do_eoc(8'hA5);
    check("t6.pass_valid", 32'(if_b.out_valid), 32'd1);
    check("t6.pass_data",  32'(if_b.out_data),  32'hA5);
    sample(8'd3);
    sample(8'd4);
    rst = 1'b1;
    tick();
    check("t6.rst_valid", 32'(if_b.out_valid),  32'd0);
    check("t6.rst_data",  32'(if_b.out_data),   32'd0);
    check("t6.rst_level", 32'(if_b.fifo_level), 32'd0);
    check("t6.rst_ovf",   32'(if_b.ovf),        32'd0);
    check("t6.avg_level", 32'(if_a.fifo_level), 32'd0);
    rst = 1'b0;
    tick();

    // Randomized traffic, including back-to-back eoc, flushes and resets
    for (int i = 0; i < 4000; i++) begin
      eoc       = ($urandom_range(0, 2) == 0);
      sar       = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    eoc = 1'b0; clr = 1'b0; rst = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
